// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential instruction prefetch queue with redirect flush.
// Optional same-cycle response forwarding: FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
  parameter int             XLEN            = 32,
  parameter int             DEPTH           = 4,
  parameter int             MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC       = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);
  localparam logic [AW:0]   MAXO_L  = (AW+1)'(MAX_OUTSTANDING);
  localparam logic [XLEN-1:0] STEP  = XLEN'(4);

  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     out_cnt;
  logic [AW:0]     out_nxt;
  logic [AW:0]     drop_cnt;
  logic [AW:0]     occ;
  logic [AW+1:0]   inflight;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] new_pc;
  logic            req_fire;
  logic            resp_keep;
  logic            wr_en;
  logic            deq;

  assign occ      = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign inflight = {1'b0, occ} + {1'b0, out_cnt};
  assign new_pc   = redirect_pc & ~XLEN'(3);

  assign mem_req_valid = !reset && !redirect
                      && (inflight < DEPTH_L)
                      && (out_cnt < MAXO_L);
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A response is kept only when nothing is left to drop and no flush is underway.
  assign resp_keep = mem_resp_valid && (drop_cnt == '0) && !redirect;
  assign deq       = inst_ready && !empty;

`ifdef FETCH_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass     = empty && resp_keep;
  assign inst_valid = !empty || bypass;
  assign inst_data  = empty ? mem_resp_data : data_q[rd_ptr[AW-1:0]];
  assign inst_pc    = empty ? resp_pc : pc_q[rd_ptr[AW-1:0]];
  assign wr_en      = resp_keep && !(bypass && inst_ready);
`else
  assign inst_valid = !empty;
  assign inst_data  = data_q[rd_ptr[AW-1:0]];
  assign inst_pc    = pc_q[rd_ptr[AW-1:0]];
  assign wr_en      = resp_keep;
`endif

  // Outstanding count after this cycle's accept and response.
  always_comb begin
    out_nxt = out_cnt;
    unique case ({req_fire, mem_resp_valid})
      2'b10:   out_nxt = out_cnt + 1'b1;
      2'b01:   out_nxt = out_cnt - 1'b1;
      default: out_nxt = out_cnt;
    endcase
  end

  // Pointers, counters and fetch/response PCs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else begin
      out_cnt <= out_nxt;
      if (redirect) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        drop_cnt <= out_nxt;
        fetch_pc <= new_pc;
        resp_pc  <= new_pc;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (mem_resp_valid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - 1'b1;
        if (resp_keep) resp_pc <= resp_pc + STEP;
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (deq) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Entry storage; written at the tail with the word and its PC.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      data_q[wr_ptr[AW-1:0]] <= mem_resp_data;
      pc_q[wr_ptr[AW-1:0]]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer.
// Memory model with configurable latency; expected PCs queued at request.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        empty;

  always #5 clk = ~clk;

  fetch_buffer #(
    .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .empty(empty)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] pend_a [$];
  int          pend_t [$];
  logic [31:0] sb_pc  [$];

  int          cyc = 0;
  int          lat = 1;
  int          n_acc = 0;
  int          n_del = 0;
  int          t_acc = -1;
  int          t_val = -1;
  logic [31:0] exp_pc = 32'h0;
  bit          got_acc, got_del;
  logic [31:0] first_acc, first_del;
  bit          r_resp, bp_v;
  logic [31:0] bp_d;
  bit          done;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] dfun(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic cycle();
    logic [31:0] e;
    if (!reset && pend_a.size() > 0 && pend_t[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = dfun(pend_a[0]);
      void'(pend_a.pop_front());
      void'(pend_t.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    @(negedge clk);
    r_resp = mem_resp_valid;
    bp_v   = inst_valid;
    bp_d   = inst_data;
    if (reset) begin
      pend_a.delete();
      pend_t.delete();
      sb_pc.delete();
      exp_pc = 32'h0;
    end else if (redirect) begin
      check("req_in_redirect", 32'(mem_req_valid), 32'd0);
      sb_pc.delete();
      exp_pc = redirect_pc & ~32'h3;
    end else begin
      if (inst_valid && inst_ready) begin
        if (sb_pc.size() == 0) begin
          check("spurious_inst", 32'(inst_valid), 32'd0);
        end else begin
          e = sb_pc.pop_front();
          check("inst_pc", inst_pc, e);
          check("inst_data", inst_data, dfun(e));
          n_del++;
          if (!got_del) begin got_del = 1; first_del = inst_pc; end
          if (t_val < 0) t_val = cyc;
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, exp_pc);
        pend_a.push_back(mem_req_addr);
        pend_t.push_back(cyc + lat);
        sb_pc.push_back(mem_req_addr);
        exp_pc += 32'd4;
        n_acc++;
        if (!got_acc) begin got_acc = 1; first_acc = mem_req_addr; end
        if (t_acc < 0) t_acc = cyc;
      end
    end
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    cyc++;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_redirect(logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    cycle();
    redirect    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    redirect = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    cycles(3);

    // reset state
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_req_issue", 32'(mem_req_valid), 32'd1);
    check("rst_req_addr", mem_req_addr, 32'h0);

    // streaming, latency 1
    cycles(20);
`ifdef FETCH_BUFFER_BYPASS_EN
    check("first_latency", 32'(t_val - t_acc), 32'd1);
`else
    check("first_latency", 32'(t_val - t_acc), 32'd2);
`endif
    check("stream_count", 32'(n_del >= 16), 32'd1);

    // backpressure fills the queue, one pop frees one request
    inst_ready = 1'b0;
    do_redirect(32'h200);
    n_acc = 0;
    cycles(12);
    check("fill_requests", 32'(n_acc), 32'd4);
    check("fill_req_idle", 32'(mem_req_valid), 32'd0);
    check("fill_head_pc", inst_pc, 32'h200);
    n_acc = 0;
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    cycles(8);
    check("one_pop_one_req", 32'(n_acc), 32'd1);
    check("after_pop_head", inst_pc, 32'h204);

    // redirect with two requests in flight
    inst_ready = 1'b1;
    lat = 3;
    do_redirect(32'h10);
    n_acc = 0;
    for (int i = 0; i < 10 && n_acc < 2; i++) cycle();
    check("two_outstanding", 32'(n_acc), 32'd2);
    got_acc = 0; got_del = 0;
    do_redirect(32'h103);
    cycles(15);
    check("redir_first_req", first_acc, 32'h100);
    check("redir_got_inst", 32'(got_del), 32'd1);
    check("redir_first_pc", first_del, 32'h100);

    // redirect coinciding with a response and a consume
    lat = 1;
    cycles(6);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      if (pend_a.size() > 0 && pend_t[0] <= cyc) begin
        done = 1;
        do_redirect(32'h300);
      end else begin
        cycle();
      end
    end
    check("redir_resp_same", 32'(done && r_resp), 32'd1);
    check("redir_empty", 32'(empty), 32'd1);
    check("redir_no_valid", 32'(inst_valid), 32'd0);
    cycles(8);

    // reset mid-stream with three entries queued
    mem_req_ready = 1'b0;
    cycles(6);
    inst_ready = 1'b0;
    mem_req_ready = 1'b1;
    n_acc = 0;
    cycles(3);
    mem_req_ready = 1'b0;
    cycles(3);
    check("three_reqs", 32'(n_acc), 32'd3);
    check("three_not_empty", 32'(empty), 32'd0);
    reset = 1'b1;
    cycle();
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    check("mid_rst_req", 32'(mem_req_valid), 32'd1);
    check("mid_rst_addr", mem_req_addr, 32'h0);
    inst_ready = 1'b1;
    cycles(10);

    // single response into an empty queue
    mem_req_ready = 1'b0;
    cycles(6);
    lat = 2;
    got_acc = 0;
    n_acc = 0;
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    check("single_req", 32'(n_acc), 32'd1);
    r_resp = 0;
    for (int i = 0; i < 6 && !r_resp; i++) cycle();
    check("single_resp_seen", 32'(r_resp), 32'd1);
`ifdef FETCH_BUFFER_BYPASS_EN
    check("bypass_valid", 32'(bp_v), 32'd1);
    check("bypass_data", bp_d, dfun(first_acc));
    check("bypass_empty", 32'(empty), 32'd1);
`else
    check("no_comb_path", 32'(bp_v), 32'd0);
    check("next_valid", 32'(inst_valid), 32'd1);
    check("next_data", inst_data, dfun(first_acc));
    cycle();
    check("drained_empty", 32'(empty), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Prefetch queue upstream of the datapath's instruction port.
- Issues sequential word fetches to a variable-latency instruction memory and buffers the returned words with their PCs.
- Presents them to the datapath through a valid/ready handshake.
- Flushes and restarts fetching at a new PC on redirect (branch, jump, trap); discards responses still in flight.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, queue entries; power of two, 2..16.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests; 1..DEPTH.
- RESET_PC, 32'h0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts request this cycle.
- mem_req_addr  out  XLEN  word-aligned fetch address.
- mem_resp_valid  in  1  response word valid; responses return in request order.
- mem_resp_data  in  XLEN  fetched instruction word.
- inst_valid  out  1  head entry valid.
- inst_ready  in  1  datapath consumes head entry.
- inst_data  out  XLEN  head instruction word.
- inst_pc  out  XLEN  PC of head instruction.
- redirect  in  1  flush queue and restart fetch.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0).
- empty  out  1  queue holds no entries.

Behaviour:
- Reset (synchronous):
  - Queue emptied; read/write pointers 0.
  - Outstanding count 0; drop count 0.
  - fetch_pc = RESET_PC.
  - Outputs: inst_valid=0, mem_req_valid=0, empty=1. inst_data and inst_pc are don't-care while inst_valid=0.
  - A reset while requests are outstanding does not drop their responses. The memory is reset by the same signal.
- Issue:
  - mem_req_valid=1 when all of: not reset, redirect=0, (occupancy + outstanding) < DEPTH, outstanding < MAX_OUTSTANDING.
  - mem_req_addr = fetch_pc.
  - On accept (mem_req_valid & mem_req_ready): fetch_pc += 4 (wraps modulo 2^XLEN); outstanding += 1.
- Response:
  - On mem_resp_valid: outstanding -= 1.
  - If drop count > 0: word discarded; drop count -= 1.
  - Otherwise: word written at tail with its PC from the response-PC register; that register then advances by 4.
  - Space is guaranteed by the issue rule, so a write never overflows.
  - Accept and response in the same cycle: outstanding unchanged.
- Dequeue:
  - inst_valid = !empty; inst_data/inst_pc driven from the head entry.
  - On inst_valid & inst_ready: head pointer advances.
  - Enqueue and dequeue in the same cycle: occupancy unchanged.
  - Full queue with dequeue and enqueue together is legal.
- Latency: response in cycle M → inst_valid in cycle M+1 when the queue was empty.
- Redirect (cycle R):
  - Queue flushed at R's edge; any same-cycle dequeue or enqueue is ignored.
  - Drop count = outstanding after R's accounting. A response arriving in cycle R is itself discarded.
  - fetch_pc and response-PC register = {redirect_pc[XLEN-1:2],2'b00}.
  - mem_req_valid=0 in cycle R; the first new request may issue in R+1.
- Redirect while drop count > 0: drop count set to current outstanding (the older count is subsumed).
- Pointers: log2(DEPTH) bits plus a wrap bit. Full/empty are decided by pointer equality and the wrap bit.
- Occupancy never exceeds DEPTH; outstanding never exceeds MAX_OUTSTANDING.

Optional Feature:
- FETCH_BUFFER_BYPASS_EN.
- Defined: when the queue is empty, drop count = 0, redirect=0 and mem_resp_valid=1, the response is forwarded combinationally.
  - inst_valid=1, inst_data=mem_resp_data, inst_pc=response-PC, all in the response cycle.
  - If inst_ready=1 in that cycle, the word is not enqueued. Otherwise it is enqueued normally.
  - Zero-cycle latency.
- Undefined: no combinational path from mem_resp_* to inst_*; latency as above (M+1).

Test Plan:
- Reset, mem_req_ready=1, memory latency 1, inst_ready=1 → requests at 0x0,0x4,0x8,… and inst_pc sequence 0x0,0x4,0x8 with matching data. Without bypass, first inst_valid 2 cycles after first request.
- inst_ready=0, DEPTH=4 → exactly 4 requests issued, then mem_req_valid stays 0. Raising inst_ready for 1 cycle produces exactly 1 new request.
- Two requests outstanding (0x10,0x14); redirect to 0x103 → both responses discarded, next request addr 0x100, first delivered inst_pc=0x100.
- Redirect in the same cycle as a response and inst_ready → queue empty the next cycle, response not delivered, no inst_pc from the old stream ever appears.
- Reset asserted mid-stream with queue at 3 entries → next cycle inst_valid=0, empty=1, mem_req_valid issues at RESET_PC.
- FETCH_BUFFER_BYPASS_EN defined, empty queue, response 0xDEADBEEF at cycle M with inst_ready=1 → inst_valid=1 and inst_data=0xDEADBEEF in cycle M, queue stays empty.
